mips_run_ctrl: RTL and testbench

//  Run/debug sequencer for the single-cycle MIPS_CPU. It gates CPU state updates via a

---
 rtl/mips_run_ctrl_pkg.sv | 42 ++++
 rtl/mips_break_unit.sv | 39 +++
 rtl/mips_run_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_mips_run_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_run_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mips_run_ctrl_pkg
//   Shared definitions for the MIPS run/debug sequencer: host command opcodes,
//   sequencer state encodings, halt cause codes and the SYSCALL encoding.
//   There are no ports. Import it with: import mips_run_ctrl_pkg::*;
// -----------------------------------------------------------------------------
package mips_run_ctrl_pkg;

   typedef enum logic [2:0] {
      OP_NOP       = 3'd0,
      OP_HALT      = 3'd1,
      OP_RUN       = 3'd2,
      OP_STEP      = 3'd3,
      OP_RUN_N     = 3'd4,
      OP_SET_BP    = 3'd5,
      OP_CLR_BP    = 3'd6,
      OP_RESET_CPU = 3'd7
   } cmd_op_e;

   typedef enum logic [2:0] {
      ST_RST   = 3'd0,
      ST_HALT  = 3'd1,
      ST_RUN   = 3'd2,
      ST_RUN_N = 3'd3,
      ST_STEP  = 3'd4
   } run_state_e;

   typedef enum logic [1:0] {
      CAUSE_HOST       = 2'd0,
      CAUSE_BREAKPOINT = 2'd1,
      CAUSE_SYSCALL    = 2'd2,
      CAUSE_COUNT      = 2'd3
   } halt_cause_e;

   localparam logic [31:0] SYSCALL_INSTR = 32'h0000_000C;

   // The CPU may commit only in these states.
   function automatic logic is_run_state(input run_state_e s);
      return (s == ST_RUN) || (s == ST_RUN_N) || (s == ST_STEP);
   endfunction

endpackage

// File: rtl/mips_break_unit.sv
// -----------------------------------------------------------------------------
// mips_break_unit
//   Combinational break detector: PC breakpoint compare plus SYSCALL decode.
//   The break is suppressed while skip_i is set, so execution can resume past
//   the instruction that caused the last halt.
// Ports
//   pc_i        in  32  CPU current PC
//   instr_i     in  32  CPU current instruction
//   bp_en_i     in  1   breakpoint armed
//   bp_addr_i   in  32  breakpoint address
//   skip_i      in  1   ignore matches for the current instruction
//   brk_o       out 1   current instruction must not commit
//   brk_cause_o out 2   BREAKPOINT if the PC matches, otherwise SYSCALL
// -----------------------------------------------------------------------------
module mips_break_unit
   import mips_run_ctrl_pkg::*;
#(
   parameter int HALT_ON_SYSCALL = 1
) (
   input  logic [31:0] pc_i,
   input  logic [31:0] instr_i,
   input  logic        bp_en_i,
   input  logic [31:0] bp_addr_i,
   input  logic        skip_i,
   output logic        brk_o,
   output halt_cause_e brk_cause_o
);

   logic bp_hit;
   logic sys_hit;

   assign bp_hit  = bp_en_i && (pc_i == bp_addr_i);
   assign sys_hit = (HALT_ON_SYSCALL != 0) && (instr_i == SYSCALL_INSTR);
   assign brk_o   = !skip_i && (bp_hit || sys_hit);

   // A PC match outranks the SYSCALL decode when both fire.
   assign brk_cause_o = bp_hit ? CAUSE_BREAKPOINT : CAUSE_SYSCALL;

endmodule

// File: rtl/mips_run_ctrl.sv
// -----------------------------------------------------------------------------
// mips_run_ctrl
//   Run/debug sequencer for the single-cycle MIPS CPU. Gates CPU commits with
//   cpu_en, drives the CPU reset, executes host commands and halts on a PC
//   breakpoint or SYSCALL.
// Ports
//   clk               in   1        rising-edge clock
//   reset             in   1        asynchronous, active-high
//   cmd_valid         in   1        host command valid
//   cmd_ready         out  1        command accepted on cmd_valid & cmd_ready
//   cmd_op            in   3        command opcode (cmd_op_e)
//   cmd_arg           in   32       RUN_N count / SET_BP address
//   cmd_err           out  1        one-cycle pulse: accepted command illegal
//   pc_debug          in   32       CPU current PC
//   instruction_debug in   32       CPU current instruction
//   cpu_en            out  1        CPU commits this cycle
//   cpu_reset         out  1        reset to the CPU
//   state             out  3        sequencer state (run_state_e)
//   halted            out  1        state == HALT
//   halt_cause        out  2        reason for the last halt (halt_cause_e)
//   retired_count     out  CYCLE_W  cycles with cpu_en = 1 (wraps)
// -----------------------------------------------------------------------------
module mips_run_ctrl
   import mips_run_ctrl_pkg::*;
#(
   parameter int CYCLE_W         = 32,
   parameter int HALT_ON_SYSCALL = 1,
   parameter int RST_CYCLES      = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [2:0]         cmd_op,
   input  logic [31:0]        cmd_arg,
   output logic               cmd_err,
   input  logic [31:0]        pc_debug,
   input  logic [31:0]        instruction_debug,
   output logic               cpu_en,
   output logic               cpu_reset,
   output logic [2:0]         state,
   output logic               halted,
   output logic [1:0]         halt_cause,
   output logic [CYCLE_W-1:0] retired_count
);

   localparam int              RC_W     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES + 1) : 1;
   localparam logic [RC_W-1:0] RST_INIT = RC_W'(RST_CYCLES);

   run_state_e         state_q;
   logic [RC_W-1:0]    rst_cnt_q;
   logic               cmd_err_q;
   halt_cause_e        halt_cause_q;
   logic [CYCLE_W-1:0] retired_q;
   logic [CYCLE_W-1:0] remaining_q;
   logic               bp_en_q;
   logic [31:0]        bp_addr_q;
   logic               skip_q;

   logic               brk;
   halt_cause_e        brk_cause;
   logic               cmd_take;
   cmd_op_e            op;
   logic               run_op;
   logic [CYCLE_W-1:0] arg_count;

   mips_break_unit #(
      .HALT_ON_SYSCALL(HALT_ON_SYSCALL)
   ) u_break (
      .pc_i       (pc_debug),
      .instr_i    (instruction_debug),
      .bp_en_i    (bp_en_q),
      .bp_addr_i  (bp_addr_q),
      .skip_i     (skip_q),
      .brk_o      (brk),
      .brk_cause_o(brk_cause)
   );

   assign cmd_take  = cmd_valid && cmd_ready;
   assign op        = cmd_op_e'(cmd_op);
   assign run_op    = (op == OP_RUN) || (op == OP_STEP) || (op == OP_RUN_N);
   assign arg_count = cmd_arg[CYCLE_W-1:0];

   // cpu_en stays combinational so a break blocks the matching instruction
   // in the very cycle it is presented.
   assign cpu_en        = is_run_state(state_q) && !brk;
   assign cpu_reset     = (state_q == ST_RST);
   assign cmd_ready     = (state_q != ST_RST);
   assign halted        = (state_q == ST_HALT);
   assign state         = state_q;
   assign cmd_err       = cmd_err_q;
   assign halt_cause    = halt_cause_q;
   assign retired_count = retired_q;

   // NOTE: sequential state uses non-blocking assignments, so every branch
   // below reads pre-edge values and later assignments override earlier ones.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_RST;
         rst_cnt_q    <= RST_INIT;
         cmd_err_q    <= 1'b0;
         halt_cause_q <= CAUSE_HOST;
         retired_q    <= '0;
         remaining_q  <= '0;
         bp_en_q      <= 1'b0;
         bp_addr_q    <= '0;
         skip_q       <= 1'b0;
      end else begin
         cmd_err_q <= 1'b0;

         if (cpu_en) begin
            retired_q <= retired_q + CYCLE_W'(1);
            skip_q    <= 1'b0;
         end
         if (cpu_en && (state_q == ST_RUN_N)) begin
            remaining_q <= remaining_q - CYCLE_W'(1);
         end

         case (state_q)
            ST_RST: begin
               // Leave on the edge that consumes the last count, giving
               // exactly RST_CYCLES cycles of cpu_reset.
               if (rst_cnt_q <= RC_W'(1)) begin
                  state_q <= ST_HALT;
               end
               if (rst_cnt_q != '0) begin
                  rst_cnt_q <= rst_cnt_q - RC_W'(1);
               end
            end

            ST_HALT: begin
               if (cmd_take) begin
                  case (op)
                     OP_RUN: begin
                        state_q <= ST_RUN;
                        skip_q  <= 1'b1;
                     end
                     OP_STEP: begin
                        state_q <= ST_STEP;
                        skip_q  <= 1'b1;
                     end
                     OP_RUN_N: begin
                        if (arg_count == '0) begin
                           halt_cause_q <= CAUSE_COUNT;
                        end else begin
                           state_q     <= ST_RUN_N;
                           remaining_q <= arg_count;
                           skip_q      <= 1'b1;
                        end
                     end
                     default: ;
                  endcase
               end
            end

            ST_RUN, ST_RUN_N, ST_STEP: begin
               if (cmd_take && run_op) begin
                  cmd_err_q <= 1'b1;
               end
               // Halt priority: break > count done > step done > host HALT.
               if (brk) begin
                  state_q      <= ST_HALT;
                  halt_cause_q <= brk_cause;
               end else if ((state_q == ST_RUN_N) && (remaining_q == CYCLE_W'(1))) begin
                  state_q      <= ST_HALT;
                  halt_cause_q <= CAUSE_COUNT;
               end else if (state_q == ST_STEP) begin
                  state_q      <= ST_HALT;
                  halt_cause_q <= CAUSE_HOST;
               end else if (cmd_take && (op == OP_HALT)) begin
                  state_q      <= ST_HALT;
                  halt_cause_q <= CAUSE_HOST;
               end
            end

            default: state_q <= ST_RST;
         endcase

         // Breakpoint and CPU-reset commands are legal in every accepting state.
         if (cmd_take) begin
            case (op)
               OP_SET_BP: begin
                  bp_addr_q <= cmd_arg;
                  bp_en_q   <= 1'b1;
               end
               OP_CLR_BP: bp_en_q <= 1'b0;
               OP_RESET_CPU: begin
                  state_q      <= ST_RST;
                  rst_cnt_q    <= RST_INIT;
                  retired_q    <= '0;
                  halt_cause_q <= CAUSE_HOST;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mips_run_ctrl
//   Self-checking bench for mips_run_ctrl. A tiny CPU stand-in advances the PC
//   on cpu_en and fetches from a program array. A behavioural model of the
//   sequencer is compared against the DUT on every falling edge, and directed
//   scenarios add hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_mips_run_ctrl;
   import mips_run_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [31:0] cmd_arg;
   logic        cmd_err;
   logic [31:0] pc_debug;
   logic [31:0] instruction_debug;
   logic        cpu_en;
   logic        cpu_reset;
   logic [2:0]  state;
   logic        halted;
   logic [1:0]  halt_cause;
   logic [31:0] retired_count;

   int n_checks = 0;
   int n_errors = 0;

   mips_run_ctrl #(
      .CYCLE_W(32), .HALT_ON_SYSCALL(1), .RST_CYCLES(2)
   ) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_arg(cmd_arg), .cmd_err(cmd_err),
      .pc_debug(pc_debug), .instruction_debug(instruction_debug),
      .cpu_en(cpu_en), .cpu_reset(cpu_reset), .state(state),
      .halted(halted), .halt_cause(halt_cause), .retired_count(retired_count)
   );

   always #5 clk = ~clk;

   // CPU stand-in: PC advances by 4 per committed instruction.
   logic [31:0] cpu_pc = 32'h0;
   logic [31:0] prog [0:63];
   always @(posedge clk) begin
      if (cpu_reset)   cpu_pc <= 32'h0;
      else if (cpu_en) cpu_pc <= cpu_pc + 32'd4;
   end
   assign pc_debug          = cpu_pc;
   assign instruction_debug = prog[cpu_pc[7:2]];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // m_mode numbering: 0 reset, 1 halted, 2 run, 3 run-N, 4 step.
   int          m_mode, m_rst_left, m_cause;
   bit          m_err, m_resume, m_bp_on;
   logic [31:0] m_bp, m_ret, m_budget;

   task automatic model_reset();
      m_mode = 0; m_rst_left = 2; m_cause = 0;
      m_err = 1'b0; m_resume = 1'b0; m_bp_on = 1'b0;
      m_bp = 32'h0; m_ret = 32'h0; m_budget = 32'h0;
   endtask

   always @(negedge clk) begin : compare
      bit running, hit_bp, hit_sys, stop, exp_en, take, last_of_n;
      if (reset) model_reset();
      running = (m_mode >= 2);
      hit_bp  = m_bp_on && (pc_debug == m_bp);
      hit_sys = (instruction_debug == 32'h0000000C);
      stop    = !m_resume && (hit_bp || hit_sys);
      exp_en  = running && !stop;

      check("cpu_en",        32'(cpu_en),     32'(exp_en));
      check("cpu_reset",     32'(cpu_reset),  32'(m_mode == 0));
      check("cmd_ready",     32'(cmd_ready),  32'(m_mode != 0));
      check("state",         32'(state),      32'(m_mode));
      check("halted",        32'(halted),     32'(m_mode == 1));
      check("halt_cause",    32'(halt_cause), 32'(m_cause));
      check("cmd_err",       32'(cmd_err),    32'(m_err));
      check("retired_count", retired_count,   m_ret);

      if (!reset) begin
         take      = cmd_valid && (m_mode != 0);
         last_of_n = (m_mode == 3) && (m_budget == 32'd1);
         m_err     = 1'b0;
         if (exp_en) begin
            m_ret    = m_ret + 32'd1;
            m_resume = 1'b0;
            if (m_mode == 3) m_budget = m_budget - 32'd1;
         end
         if (m_mode == 0) begin
            if (m_rst_left <= 1) m_mode = 1;
            else m_rst_left--;
         end else if (m_mode == 1) begin
            if (take && cmd_op == OP_RUN) begin
               m_mode = 2; m_resume = 1'b1;
            end else if (take && cmd_op == OP_STEP) begin
               m_mode = 4; m_resume = 1'b1;
            end else if (take && cmd_op == OP_RUN_N) begin
               if (cmd_arg == 32'd0) m_cause = 3;
               else begin m_mode = 3; m_budget = cmd_arg; m_resume = 1'b1; end
            end
         end else begin
            if (take && (cmd_op == OP_RUN || cmd_op == OP_STEP || cmd_op == OP_RUN_N))
               m_err = 1'b1;
            if (stop)                            begin m_mode = 1; m_cause = hit_bp ? 1 : 2; end
            else if (last_of_n)                  begin m_mode = 1; m_cause = 3; end
            else if (m_mode == 4)                begin m_mode = 1; m_cause = 0; end
            else if (take && cmd_op == OP_HALT)  begin m_mode = 1; m_cause = 0; end
         end
         if (take && cmd_op == OP_SET_BP) begin m_bp = cmd_arg; m_bp_on = 1'b1; end
         if (take && cmd_op == OP_CLR_BP) m_bp_on = 1'b0;
         if (take && cmd_op == OP_RESET_CPU) begin
            m_mode = 0; m_rst_left = 2; m_ret = 32'h0; m_cause = 0;
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input cmd_op_e op, input logic [31:0] arg);
      cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
      step();
      cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_arg = 32'h0;
   endtask

   task automatic wait_halted(input string name, input int budget);
      for (int i = 0; i < budget && !halted; i++) step();
      check(name, 32'(halted), 32'd1);
   endtask

   initial begin
      int en_cycles;
      cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_arg = 32'h0;
      for (int i = 0; i < 64; i++) prog[i] = 32'h0;

      // 1. reset for 3 cycles, then exactly 2 cycles of cpu_reset
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      check("t1_cpu_reset_c1", 32'(cpu_reset), 32'd1);
      check("t1_ready_c1",     32'(cmd_ready), 32'd0);
      check("t1_en_c1",        32'(cpu_en),    32'd0);
      step();
      check("t1_cpu_reset_c2", 32'(cpu_reset), 32'd1);
      check("t1_ready_c2",     32'(cmd_ready), 32'd0);
      step();
      check("t1_cpu_reset_c3", 32'(cpu_reset), 32'd0);
      check("t1_state_halt",   32'(state),     32'd1);
      check("t1_ready_c3",     32'(cmd_ready), 32'd1);

      // 2. RUN_N 5
      send(OP_RUN_N, 32'd5);
      en_cycles = 0;
      for (int i = 0; i < 10; i++) begin
         if (cpu_en) en_cycles++;
         step();
      end
      check("t2_en_cycles", 32'(en_cycles),     32'd5);
      check("t2_retired",   retired_count,      32'd5);
      check("t2_halted",    32'(halted),        32'd1);
      check("t2_cause",     32'(halt_cause),    32'd3);

      // 3. breakpoint at 0x10, then step over it
      send(OP_RESET_CPU, 32'h0);
      wait_halted("t3_reset_done", 10);
      check("t3_retired_clr", retired_count, 32'd0);
      send(OP_SET_BP, 32'h10);
      send(OP_RUN, 32'h0);
      wait_halted("t3_bp_halt", 20);
      check("t3_pc",      pc_debug,         32'h10);
      check("t3_cause",   32'(halt_cause),  32'd1);
      check("t3_retired", retired_count,    32'd4);
      send(OP_STEP, 32'h0);
      wait_halted("t3_step_halt", 5);
      check("t3_step_pc",      pc_debug,        32'h14);
      check("t3_step_cause",   32'(halt_cause), 32'd0);
      check("t3_step_retired", retired_count,   32'd5);

      // 4. SYSCALL at 0x8
      send(OP_CLR_BP, 32'h0);
      send(OP_RESET_CPU, 32'h0);
      wait_halted("t4_reset_done", 10);
      prog[2] = 32'h0000000C;
      send(OP_RUN, 32'h0);
      wait_halted("t4_sys_halt", 20);
      check("t4_pc",      pc_debug,        32'h8);
      check("t4_cause",   32'(halt_cause), 32'd2);
      check("t4_retired", retired_count,   32'd2);
      send(OP_RUN, 32'h0);
      repeat (3) step();
      check("t4_running",     32'(state),    32'd2);
      check("t4_retired_run", retired_count, 32'd5);
      check("t4_pc_run",      pc_debug,      32'h14);

      // 5. illegal RUN while running, RESET_CPU mid-run, RUN_N 0
      send(OP_RUN, 32'h0);
      check("t5_err_pulse", 32'(cmd_err), 32'd1);
      check("t5_state_run", 32'(state),   32'd2);
      step();
      check("t5_err_clear", 32'(cmd_err), 32'd0);
      send(OP_RESET_CPU, 32'h0);
      check("t5_cpu_reset_c1", 32'(cpu_reset), 32'd1);
      check("t5_retired_clr",  retired_count,  32'd0);
      step();
      check("t5_cpu_reset_c2", 32'(cpu_reset), 32'd1);
      step();
      check("t5_cpu_reset_c3", 32'(cpu_reset), 32'd0);
      check("t5_halted",       32'(halted),    32'd1);
      send(OP_RUN_N, 32'd0);
      check("t5_runn0_halted", 32'(halted),     32'd1);
      check("t5_runn0_cause",  32'(halt_cause), 32'd3);
      check("t5_runn0_err",    32'(cmd_err),    32'd0);

      // 6. HALT command in the same cycle as a breakpoint match
      prog[2] = 32'h0;
      send(OP_SET_BP, 32'h8);
      send(OP_RUN, 32'h0);
      step();
      step();
      check("t6_pc_at_bp", pc_debug,     32'h8);
      check("t6_en_at_bp", 32'(cpu_en),  32'd0);
      send(OP_HALT, 32'h0);
      check("t6_halted",  32'(halted),     32'd1);
      check("t6_cause",   32'(halt_cause), 32'd1);
      check("t6_retired", retired_count,   32'd2);

      // async reset in the middle of RUN_N
      send(OP_CLR_BP, 32'h0);
      send(OP_RUN_N, 32'd10);
      step();
      check("t6_runn_en", 32'(cpu_en), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("t6_async_en",      32'(cpu_en),    32'd0);
      check("t6_async_state",   32'(state),     32'd0);
      check("t6_async_creset",  32'(cpu_reset), 32'd1);
      check("t6_async_retired", retired_count,  32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      wait_halted("t6_after_reset", 10);
      check("t6_after_cause", 32'(halt_cause), 32'd0);
      step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
